// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: tracks in-flight register writers and
// resolves decode read ports to a bypass select or a stall.
module fwd_scoreboard #(
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 3,
    parameter int NRP         = 2,
    parameter int SEL_W       = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [ADDR_W-1:0]     issue_dest,
    input  logic [SEL_W-1:0]      issue_rdy_stage,
    input  logic [NRP-1:0]        rd_en,
    input  logic [NRP*ADDR_W-1:0] rd_addr,
    output logic [NRP*SEL_W-1:0]  fw_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [SEL_W:0]        occupancy
);

    logic [DEPTH-1:0]  slot_v;
    logic [DEPTH-1:0]  slot_we;
    logic [ADDR_W-1:0] slot_dest [DEPTH];
    logic [SEL_W-1:0]  slot_rdy  [DEPTH];
    logic [NRP-1:0]    req;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fw_sel = '0;
        req    = '0;
        for (int p = 0; p < NRP; p++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (rd_en[p] && slot_v[i] && slot_we[i] &&
                    slot_dest[i] == rd_addr[p*ADDR_W +: ADDR_W] &&
                    rd_addr[p*ADDR_W +: ADDR_W] != '0) begin
                    if (SEL_W'(i) >= slot_rdy[i]) begin
                        fw_sel[p*SEL_W +: SEL_W] = SEL_W'(i + 1);
                        req[p] = 1'b0;
                    end else begin
                        fw_sel[p*SEL_W +: SEL_W] = '0;
                        req[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = issue_valid & (|req);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + (SEL_W+1)'(slot_v[i]);
    end

    // Flush is applied after the shift, so it also kills the incoming issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v    <= '0;
            stall_cnt <= '0;
        end else begin
            if (advance) begin
                for (int i = DEPTH - 1; i > 0; i--)
                    slot_v[i] <= slot_v[i-1];
                slot_v[0] <= issue_valid & ~stall;
            end
            if (flush) begin
                for (int i = 0; i < FLUSH_DEPTH; i++)
                    slot_v[i] <= 1'b0;
            end
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Payload fields are only meaningful under slot_v, so they need no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_we[i]   <= slot_we[i-1];
                slot_dest[i] <= slot_dest[i-1];
                slot_rdy[i]  <= slot_rdy[i-1];
            end
            slot_we[0]   <= issue_we;
            slot_dest[0] <= issue_dest;
            slot_rdy[0]  <= issue_rdy_stage;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (CNT_W=4 build to reach
// counter saturation quickly).
module tb_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       advance;
    logic       flush;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_dest;
    logic [1:0] issue_rdy_stage;
    logic [1:0] rd_en;
    logic [9:0] rd_addr;
    logic [3:0] fw_sel;
    logic       stall;
    logic [3:0] stall_cnt;
    logic [2:0] occupancy;

    typedef struct {
        logic [1:0] s0;
        logic [1:0] s1;
        logic       st;
        logic [2:0] occ;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] ecnt;
    int         npass = 0;
    int         ntot  = 0;

    fwd_scoreboard #(
        .ADDR_W(5), .DEPTH(3), .NRP(2), .SEL_W(2),
        .FLUSH_DEPTH(1), .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .advance(advance),
        .flush(flush),
        .issue_valid(issue_valid),
        .issue_we(issue_we),
        .issue_dest(issue_dest),
        .issue_rdy_stage(issue_rdy_stage),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .fw_sel(fw_sel),
        .stall(stall),
        .stall_cnt(stall_cnt),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntot++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // One cycle: drive after negedge, push expectation, sample before posedge.
    task automatic cyc(input string tag,
                       input logic adv, input logic fl,
                       input logic iv, input logic iwe,
                       input logic [4:0] idst, input logic [1:0] irdy,
                       input logic [1:0] en,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic st, input logic [2:0] occ);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        advance = adv;
        flush = fl;
        issue_valid = iv;
        issue_we = iwe;
        issue_dest = idst;
        issue_rdy_stage = irdy;
        rd_en = en;
        rd_addr = {a1, a0};
        e.s0 = s0;
        e.s1 = s1;
        e.st = st;
        e.occ = occ;
        e.cnt = ecnt;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        check({tag, ".sel0"}, 32'(fw_sel[1:0]), 32'(e.s0));
        check({tag, ".sel1"}, 32'(fw_sel[3:2]), 32'(e.s1));
        check({tag, ".stall"}, 32'(stall), 32'(e.st));
        check({tag, ".occ"}, 32'(occupancy), 32'(e.occ));
        check({tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
        if (e.st && ecnt != 4'hF) ecnt = ecnt + 4'd1;
    endtask

    task automatic rand_drive();
        advance = 1'b1;
        flush = 1'($urandom);
        issue_valid = 1'($urandom);
        issue_we = 1'($urandom);
        issue_dest = 5'($urandom);
        issue_rdy_stage = 2'($urandom_range(0, 1));
        rd_en = 2'($urandom);
        rd_addr = 10'($urandom);
    endtask

    initial begin
        ecnt = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        rand_drive();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst = 1'b0;
            rand_drive();
            issue_valid = 1'b1;
            issue_we = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        rand_drive();

        // reset state
        cyc("rst", 1, 0, 0, 0, 0, 0, 2'b11, 5, 7, 0, 0, 0, 0);

        // ALU writer r5 walks down the pipe
        cyc("alu0", 1, 0, 1, 1, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc("alu1", 1, 0, 1, 0, 0, 0, 2'b01, 5, 0, 1, 0, 0, 1);
        cyc("alu2", 1, 0, 0, 0, 0, 0, 2'b01, 5, 0, 2, 0, 0, 2);
        cyc("alu3", 1, 0, 0, 0, 0, 0, 2'b01, 5, 0, 3, 0, 0, 2);
        cyc("alu4", 1, 0, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0, 1);

        // load r7 then dependent reader: one bubble
        cyc("ld0", 1, 0, 1, 1, 7, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc("ld1", 1, 0, 1, 0, 0, 0, 2'b10, 0, 7, 0, 0, 1, 1);
        cyc("ld2", 1, 0, 1, 0, 0, 0, 2'b10, 0, 7, 0, 2, 0, 1);
        cyc("ld3", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2);
        cyc("ld4", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        cyc("ld5", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

        // two writers of r3, youngest wins; r0 never matches
        cyc("yw0", 1, 0, 1, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc("yw1", 1, 0, 1, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        cyc("yw2", 1, 0, 1, 1, 0, 1, 2'b11, 3, 3, 1, 1, 0, 2);
        cyc("r0", 1, 0, 0, 0, 0, 0, 2'b11, 0, 3, 0, 2, 0, 3);
        cyc("yw3", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2);
        cyc("yw4", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

        // flush with advance: incoming r9 dropped, r4/r6 shift on
        cyc("fl0", 1, 0, 1, 1, 6, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc("fl1", 1, 0, 1, 1, 4, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        cyc("fl2", 1, 1, 1, 1, 9, 0, 2'b11, 4, 6, 1, 2, 0, 2);
        cyc("fl3", 1, 0, 0, 0, 0, 0, 2'b11, 4, 6, 2, 3, 0, 2);
        cyc("fl4", 1, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 0, 1);

        // flush without advance kills the held slot 0
        cyc("fh0", 1, 0, 1, 1, 8, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc("fh1", 0, 1, 1, 0, 0, 0, 2'b01, 8, 0, 0, 0, 1, 1);
        cyc("fh2", 1, 0, 1, 0, 0, 0, 2'b01, 8, 0, 0, 0, 0, 0);

        // held load hazard saturates the counter
        cyc("sat0", 1, 0, 1, 1, 7, 1, 2'b00, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 21; k++)
            cyc("sat", 0, 0, 1, 0, 0, 0, 2'b01, 7, 0, 0, 0, 1, 2);
        cyc("satend", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
